// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
// Forwarding and load-use hazard controller at the decode/execute boundary.
// Tracks the destinations of the two instructions ahead of decode (EX, MEM)
// and steers both ALU operand bypass muxes. Raises a one-cycle stall when a
// decoded instruction reads the result of a load that is still in EX.
//
// Optional feature macro: FWD_ZERO_REG_EN
//   defined   -> r0 is hardwired zero; producers with rd=0 never match.
//   undefined -> r0 is an ordinary register.
//
// Ports:
//   i_clk        pipeline clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_id_valid   decode stage holds a real instruction
//   i_id_ra/rb   source register addresses
//   i_id_use_ra/rb  instruction reads the corresponding source
//   i_id_rd      destination register
//   i_id_we      instruction writes i_id_rd
//   i_id_load    instruction is a memory load
//   i_flush      kill the decode instruction (branch taken)
//   o_fwd_a/b    forward enable for operand A/B mux
//   o_sel_a/b    bypass source: 01 EX/MEM, 10 MEM/WB, 00 none
//   o_stall      hold PC and IF/ID, inject bubble into EX
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_id_valid,
  input  logic [AW-1:0] i_id_ra,
  input  logic [AW-1:0] i_id_rb,
  input  logic          i_id_use_ra,
  input  logic          i_id_use_rb,
  input  logic [AW-1:0] i_id_rd,
  input  logic          i_id_we,
  input  logic          i_id_load,
  input  logic          i_flush,
  output logic          o_fwd_a,
  output logic          o_fwd_b,
  output logic [1:0]    o_sel_a,
  output logic [1:0]    o_sel_b,
  output logic          o_stall
);

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_EX   = 2'b01;
  localparam logic [1:0] SEL_MEM  = 2'b10;

  // Tracker entries: control bits carry reset, rd is plain data.
  logic          r_ex_v,  r_ex_we,  r_ex_ld;
  logic [AW-1:0] r_ex_rd;
  logic          r_mem_v, r_mem_we, r_mem_ld;
  logic [AW-1:0] r_mem_rd;

  logic w_a_ex, w_a_mem, w_b_ex, w_b_mem;
  logic w_a_lu, w_b_lu;

  // Producer/consumer match for one operand against one tracker entry.
  function automatic logic f_match(input logic          v,
                                   input logic          we,
                                   input logic [AW-1:0] rd,
                                   input logic [AW-1:0] src);
`ifdef FWD_ZERO_REG_EN
    f_match = v & we & (rd == src) & (rd != '0);
`else
    f_match = v & we & (rd == src);
`endif
  endfunction

  // ---- decode stage: combinational hazard resolution ----
  always_comb begin
    w_a_ex  = i_id_valid & i_id_use_ra & f_match(r_ex_v,  r_ex_we,  r_ex_rd,  i_id_ra);
    w_a_mem = i_id_valid & i_id_use_ra & f_match(r_mem_v, r_mem_we, r_mem_rd, i_id_ra);
    w_b_ex  = i_id_valid & i_id_use_rb & f_match(r_ex_v,  r_ex_we,  r_ex_rd,  i_id_rb);
    w_b_mem = i_id_valid & i_id_use_rb & f_match(r_mem_v, r_mem_we, r_mem_rd, i_id_rb);

    // Load in EX: data not yet available; the MEM entry is deliberately not
    // consulted for that operand since it holds an older value.
    w_a_lu  = w_a_ex & r_ex_ld;
    w_b_lu  = w_b_ex & r_ex_ld;

    o_fwd_a = 1'b0;
    o_sel_a = SEL_NONE;
    o_fwd_b = 1'b0;
    o_sel_b = SEL_NONE;
    o_stall = 1'b0;

    // A flushed decode instruction is discarded: no stall, no forwarding.
    if (!i_flush) begin
      o_stall = w_a_lu | w_b_lu;

      if (w_a_ex) begin
        if (!r_ex_ld) begin
          o_fwd_a = 1'b1;
          o_sel_a = SEL_EX;
        end
      end else if (w_a_mem) begin
        o_fwd_a = 1'b1;
        o_sel_a = SEL_MEM;
      end

      if (w_b_ex) begin
        if (!r_ex_ld) begin
          o_fwd_b = 1'b1;
          o_sel_b = SEL_EX;
        end
      end else if (w_b_mem) begin
        o_fwd_b = 1'b1;
        o_sel_b = SEL_MEM;
      end
    end
  end

  // ---- decode -> EX -> MEM tracker advance ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex_v   <= 1'b0;
      r_ex_we  <= 1'b0;
      r_ex_ld  <= 1'b0;
      r_mem_v  <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_ld <= 1'b0;
    end else begin
      // Stall and flush both turn the EX entry into a bubble.
      r_ex_v   <= i_id_valid & ~i_flush & ~o_stall;
      r_ex_we  <= i_id_we;
      r_ex_ld  <= i_id_load;
      r_mem_v  <= r_ex_v;
      r_mem_we <= r_ex_we;
      r_mem_ld <= r_ex_ld;
    end
  end

  always_ff @(posedge i_clk) begin
    r_ex_rd  <= i_id_rd;
    r_mem_rd <= r_ex_rd;
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [AW-1:0] id_ra, id_rb, id_rd;
  logic          id_use_ra, id_use_rb, id_we, id_load, flush;
  logic          fwd_a, fwd_b, stall;
  logic [1:0]    sel_a, sel_b;

  fwd_hazard_unit #(.AW(AW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_id_valid  (id_valid),
    .i_id_ra     (id_ra),
    .i_id_rb     (id_rb),
    .i_id_use_ra (id_use_ra),
    .i_id_use_rb (id_use_rb),
    .i_id_rd     (id_rd),
    .i_id_we     (id_we),
    .i_id_load   (id_load),
    .i_flush     (flush),
    .o_fwd_a     (fwd_a),
    .o_fwd_b     (fwd_b),
    .o_sel_a     (sel_a),
    .o_sel_b     (sel_b),
    .o_stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] exp;   // {fwd_a, sel_a, fwd_b, sel_b, stall}
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Expected-vector builder: operand A fields, operand B fields, stall.
  function automatic logic [6:0] ev(input logic fa, input logic [1:0] sa,
                                    input logic fb, input logic [1:0] sb,
                                    input logic st);
    return {fa, sa, fb, sb, st};
  endfunction

  task automatic expect_out(input logic [6:0] e, input string tag);
    exp_t item;
    item.exp = e;
    item.tag = tag;
    exp_q.push_back(item);
  endtask

  task automatic check_out();
    exp_t       item;
    logic [6:0] obs;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    item = exp_q.pop_front();
    obs  = {fwd_a, sel_a, fwd_b, sel_b, stall};
    checks++;
    assert (obs === item.exp) else begin
      errors++;
      $error("FAIL %s observed={fa,sa,fb,sb,st}=%b expected=%b", item.tag, obs, item.exp);
    end
  endtask

  // One decode cycle: drive at the falling edge, compare combinational
  // outputs before the next rising edge updates the tracker.
  task automatic step(input logic v,
                      input logic [AW-1:0] ra, input logic ura,
                      input logic [AW-1:0] rb, input logic urb,
                      input logic [AW-1:0] rd, input logic we, input logic ld,
                      input logic fl,
                      input logic [6:0] e, input string tag);
    @(negedge clk);
    id_valid  = v;
    id_ra     = ra;
    id_use_ra = ura;
    id_rb     = rb;
    id_use_rb = urb;
    id_rd     = rd;
    id_we     = we;
    id_load   = ld;
    flush     = fl;
    expect_out(e, tag);
    #2;
    check_out();
  endtask

  task automatic idle_inputs();
    id_valid  = 1'b0;
    id_ra     = '0;
    id_rb     = '0;
    id_rd     = '0;
    id_use_ra = 1'b0;
    id_use_rb = 1'b0;
    id_we     = 1'b0;
    id_load   = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] zero_cons;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    expect_out(ev(0, 2'b00, 0, 2'b00, 0), "reset_state");
    check_out();
    @(negedge clk);
    rst_n = 1'b1;

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, ev(0, 2'b00, 0, 2'b00, 0), "idle_after_reset");

    // ALU back-to-back
    step(1, 3, 0, 0, 0, 3, 1, 0, 0, ev(0, 2'b00, 0, 2'b00, 0), "alu_producer_r3");
    step(1, 3, 1, 0, 0, 0, 0, 0, 0, ev(1, 2'b01, 0, 2'b00, 0), "alu_b2b_fwd_a_ex");

    // Distance two on operand B
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, ev(0, 2'b00, 0, 2'b00, 0), "producer_r5");
    step(1, 0, 0, 0, 0, 6, 1, 0, 0, ev(0, 2'b00, 0, 2'b00, 0), "unrelated_r6");
    step(1, 0, 0, 5, 1, 0, 0, 0, 0, ev(0, 2'b00, 1, 2'b10, 0), "dist2_fwd_b_mem");

    // Load-use on both operands
    step(1, 0, 0, 0, 0, 7, 1, 1, 0, ev(0, 2'b00, 0, 2'b00, 0), "load_r7");
    step(1, 7, 1, 7, 1, 0, 0, 0, 0, ev(0, 2'b00, 0, 2'b00, 1), "load_use_stall");
    step(1, 7, 1, 7, 1, 0, 0, 0, 0, ev(1, 2'b10, 1, 2'b10, 0), "load_use_release");

    // Youngest producer wins
    step(1, 0, 0, 0, 0, 2, 1, 0, 0, ev(0, 2'b00, 0, 2'b00, 0), "producer_r2_old");
    step(1, 0, 0, 0, 0, 2, 1, 0, 0, ev(0, 2'b00, 0, 2'b00, 0), "producer_r2_young");
    step(1, 2, 1, 0, 0, 0, 0, 0, 0, ev(1, 2'b01, 0, 2'b00, 0), "priority_ex_over_mem");

    // Flush beats stall; the flushed writer of r9 must not enter EX
    step(1, 0, 0, 0, 0, 4, 1, 1, 0, ev(0, 2'b00, 0, 2'b00, 0), "load_r4");
    step(1, 4, 1, 0, 0, 9, 1, 0, 1, ev(0, 2'b00, 0, 2'b00, 0), "flush_kills_stall");
    step(1, 4, 1, 9, 1, 0, 0, 0, 0, ev(1, 2'b10, 0, 2'b00, 0), "after_flush_ex_bubble");

    // r0 handling
`ifdef FWD_ZERO_REG_EN
    zero_cons = ev(0, 2'b00, 0, 2'b00, 0);
`else
    zero_cons = ev(1, 2'b01, 0, 2'b00, 0);
`endif
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, ev(0, 2'b00, 0, 2'b00, 0), "producer_r0");
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, zero_cons, "consumer_r0");

    // Asynchronous reset mid-stream
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, ev(0, 2'b00, 0, 2'b00, 0), "producer_r3_again");
    step(1, 3, 1, 0, 0, 0, 0, 0, 0, ev(1, 2'b01, 0, 2'b00, 0), "pre_reset_fwd");
    #1;
    rst_n = 1'b0;
    #1;
    expect_out(ev(0, 2'b00, 0, 2'b00, 0), "async_reset_immediate");
    check_out();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 3, 1, 3, 1, 0, 0, 0, 0, ev(0, 2'b00, 0, 2'b00, 0), "post_reset_empty");

    // Load-use on operand B only, A unrelated
    step(1, 0, 0, 0, 0, 8, 1, 1, 0, ev(0, 2'b00, 0, 2'b00, 0), "load_r8");
    step(1, 1, 1, 8, 1, 0, 0, 0, 0, ev(0, 2'b00, 0, 2'b00, 1), "load_use_b_stall");
    step(1, 1, 1, 8, 1, 0, 0, 0, 0, ev(0, 2'b00, 1, 2'b10, 0), "load_use_b_release");

    // Invalid decode never forwards
    step(1, 0, 0, 0, 0, 11, 1, 0, 0, ev(0, 2'b00, 0, 2'b00, 0), "producer_r11");
    step(0, 11, 1, 11, 1, 0, 0, 0, 0, ev(0, 2'b00, 0, 2'b00, 0), "invalid_consumer");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
